// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter for divider bring-up self-check.
// Counts synchronised rising edges of meas_clk_i over GATE_CYCLES clk_i
// cycles and returns the result over a valid/ready handshake.
// Optional macro FREQ_METER_DUTY_EN builds the high-time (duty) counter;
// without it high_o is tied to 0.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int          CNT_W       = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             meas_clk_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] high_o
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_last;
  logic                   meas_edge;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       edge_nxt;
  logic                   ovf_acc;
  logic                   ovf_nxt;
  logic                   gate_end;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign meas_edge = sync_last & ~prev_q;
  assign gate_end  = (state == GATE) && (gate_cnt == GATE_LAST);

  // Synchroniser and edge-detect flops run in every state so a window never
  // starts with a stale prev value and a false edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
      prev_q <= sync_last;
    end
  end

  // Saturating edge accumulation; ovf flags an edge lost at saturation.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_acc;
    if (meas_edge) begin
      if (edge_cnt == CNT_MAX) ovf_nxt  = 1'b1;
      else                     edge_nxt = edge_cnt + CNT_W'(1);
    end
  end

  // Control FSM with registered busy/valid and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      cnt_o    <= '0;
      ovf_o    <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= GATE;
            busy_o   <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
          end
        end
        GATE: begin
          if (gate_end) begin
            // Final window cycle: its edge is folded into the result.
            state   <= HOLD;
            valid_o <= 1'b1;
            cnt_o   <= edge_nxt;
            ovf_o   <= ovf_nxt;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
            ovf_acc  <= ovf_nxt;
          end
        end
        HOLD: begin
          // start_i is deliberately not looked at here, even on the handshake.
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] high_nxt;
  logic [CNT_W-1:0] high_q;

  assign high_nxt = (sync_last && high_cnt != CNT_MAX) ? high_cnt + CNT_W'(1) : high_cnt;
  assign high_o   = high_q;

  // High-time counter: clk_i cycles with synced meas high, saturating.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      high_cnt <= '0;
      high_q   <= '0;
    end else if (state == IDLE && start_i) begin
      high_cnt <= '0;
    end else if (state == GATE) begin
      high_cnt <= high_nxt;
      if (gate_end) high_q <= high_nxt;
    end
  end
`else
  assign high_o = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard bench for freq_meter. Two instances share all
// inputs: a 16-bit one and an 8-bit one that saturates on fast inputs.
// Both complete each window on the same cycle, so one queue entry holds the
// expectations for both.
module tb_freq_meter;

`ifdef FREQ_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;

  logic v16, b16, o16, v8, b8, o8;
  logic [15:0] c16, h16;
  logic [7:0]  c8, h8;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .meas_clk_i(meas), .start_i(start),
    .busy_o(b16), .valid_o(v16), .ready_i(ready), .cnt_o(c16),
    .ovf_o(o16), .high_o(h16));

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(8), .SYNC_STAGES(2)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .meas_clk_i(meas), .start_i(start),
    .busy_o(b8), .valid_o(v8), .ready_i(ready), .cnt_o(c8),
    .ovf_o(o8), .high_o(h8));

  typedef struct {
    int clo, chi;
    int slo, shi;
    bit sovf;
    int hlo, hhi;
    int h8lo, h8hi;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Pattern generator: period per (0 = constant lvl), high for hi clocks.
  int per = 0;
  int hi = 0;
  bit lvl = 1'b0;
  int ph = 0;
  always @(negedge clk) begin
    if (per == 0) meas <= lvl;
    else begin
      ph   <= (ph >= per - 1) ? 0 : ph + 1;
      meas <= (ph < hi);
    end
  end

  task automatic chk(input string name, input int act, input int lo, input int hi_);
    total++;
    if (act < lo || act > hi_) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi_);
    end
  endtask

  function automatic exp_t mk(int clo, int chi, int slo, int shi, bit sovf,
                              int hlo, int hhi, int h8lo, int h8hi);
    exp_t e;
    e.clo = clo; e.chi = chi; e.slo = slo; e.shi = shi; e.sovf = sovf;
    e.hlo = DUTY ? hlo : 0;  e.hhi = DUTY ? hhi : 0;
    e.h8lo = DUTY ? h8lo : 0; e.h8hi = DUTY ? h8hi : 0;
    return e;
  endfunction

  // Monitor: on every accepted result, pop and compare.
  always @(negedge clk) begin
    if (rst_n && v16 && ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got cnt=%0d want no result", c16);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cnt16", int'(c16), e.clo, e.chi);
        chk("ovf16", int'(o16), 0, 0);
        chk("cnt8", int'(c8), e.slo, e.shi);
        chk("ovf8", int'(o8), int'(e.sovf), int'(e.sovf));
        chk("high16", int'(h16), e.hlo, e.hhi);
        chk("high8", int'(h8), e.h8lo, e.h8hi);
        chk("valid8", int'(v8), 1, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle(input int p, input int h, input bit l);
    per = p; hi = h; lvl = l;
    repeat (12) step();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!v16 && n < 3000) begin step(); n++; end
    if (!v16) begin
      total++; bad++;
      $display("FAIL valid_timeout: got valid=0 want valid=1 within 3000 cycles");
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_meas(input int p, input int h, input bit l, input exp_t e,
                          input bit chk_lat);
    int n, m;
    settle(p, h, l);
    q.push_back(e);
    pulse_start();
    chk("busy_after_start", int'(b16), 1, 1);
    wait_valid(n);
    if (chk_lat) chk("latency", n, 1000, 1000);
    m = 0;
    while (b16 && m < 10) begin step(); m++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end want end before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit vs, bs, cs;
    logic [15:0] snap;

    // Reset state
    #12;
    chk("rst_valid", int'(v16), 0, 0);
    chk("rst_busy", int'(b16), 0, 0);
    chk("rst_cnt", int'(c16), 0, 0);
    chk("rst_ovf", int'(o16), 0, 0);
    chk("rst_high", int'(h16), 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // clk/2, div4, div8, div3, constant 0, constant 1
    run_meas(2, 1, 0, mk(499, 501, 255, 255, 1, 498, 502, 255, 255), 1'b1);
    run_meas(4, 2, 0, mk(249, 251, 249, 251, 0, 498, 502, 255, 255), 1'b1);
    run_meas(8, 4, 0, mk(124, 126, 124, 126, 0, 496, 504, 255, 255), 1'b0);
    run_meas(3, 1, 0, mk(332, 334, 255, 255, 1, 331, 335, 255, 255), 1'b0);
    run_meas(0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    run_meas(0, 0, 1, mk(0, 0, 0, 0, 0, 1000, 1000, 255, 255), 1'b0);

    // Backpressure in HOLD: result held, start ignored
    settle(2, 1, 0);
    q.push_back(mk(499, 501, 255, 255, 1, 498, 502, 255, 255));
    ready = 1'b0;
    pulse_start();
    wait_valid(n);
    snap = c16; vs = 1; bs = 1; cs = 1;
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      step();
      if (!v16) vs = 0;
      if (!b16) bs = 0;
      if (c16 != snap) cs = 0;
    end
    chk("hold_valid_stable", int'(vs), 1, 1);
    chk("hold_busy", int'(bs), 1, 1);
    chk("hold_cnt_stable", int'(cs), 1, 1);
    // start coincident with the handshake must be ignored
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    chk("hs_valid_drop", int'(v16), 0, 0);
    chk("hs_busy_drop", int'(b16), 0, 0);
    step();
    chk("no_queued_start", int'(b16), 0, 0);
    chk("result_kept", int'(c16), int'(snap), int'(snap));

    // Reset mid-window at gate_cnt=400
    settle(2, 1, 0);
    pulse_start();
    repeat (400) step();
    chk("pre_rst_busy", int'(b16), 1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(b16), 0, 0);
    chk("mid_rst_cnt", int'(c16), 0, 0);
    chk("mid_rst_cnt8", int'(c8), 0, 0);
    chk("mid_rst_ovf8", int'(o8), 0, 0);
    chk("mid_rst_high", int'(h16), 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", int'(v16), 0, 0);
    chk("post_rst_busy", int'(b16), 0, 0);
    run_meas(2, 1, 0, mk(499, 501, 255, 255, 1, 498, 502, 255, 255), 1'b1);

    repeat (5) step();
    chk("queue_empty", q.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
